arbitro_registrador: RTL and testbench

ARBITRO_REGISTRADOR -- requirements
Module: arbitro_registrador

---
 rtl/arbitro_registrador_pkg.sv | 49 ++++
 rtl/arbitro_registrador_if.sv | 45 ++++
 rtl/arbitro_registrador_carga.sv | 39 +++
 rtl/arbitro_registrador.sv | 103 ++++++++++
 tb/tb_arbitro_registrador.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/arbitro_registrador_pkg.sv
// registrador_pkg: shared sizes, FSM states, select codes and
// the round-robin pick used by arbitro_registrador.
// No ports; imported by the interface, register and arbiter files.
package registrador_pkg;

    localparam int WIDTH = 4;
    localparam int N_REQ = 3;

    typedef enum logic [1:0] {
        OCIOSO,
        CONCEDE,
        CARREGA,
        CONFIRMA
    } estado_t;

    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_C = 2'd2;

    // Next requester index, wrapping C back to A.
    function automatic logic [1:0] prox_sel(
        input logic [1:0] s
    );
        return (s == SEL_C) ? SEL_A : s + 2'd1;
    endfunction

    // First set request bit, searching from ptr upward (mod 3).
    // Callers only use the result when at least one bit is set.
    function automatic logic [1:0] escolhe(
        input logic [2:0] req,
        input logic [1:0] ptr
    );
        logic [1:0] idx;
        logic [1:0] res;
        logic       achou;
        idx   = ptr;
        res   = ptr;
        achou = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!achou && req[idx]) begin
                res   = idx;
                achou = 1'b1;
            end
            idx = prox_sel(idx);
        end
        return res;
    endfunction

endpackage

// File: rtl/arbitro_registrador_if.sv
// arbitro_registrador_if: requester/arbiter bundle.
// master: drives req, entradaA/B/C; sees ack, sel_mux, enable,
//   saida_registrador, ocupado, contador. slave: the reverse.
interface arbitro_registrador_if #(
    parameter int WIDTH = registrador_pkg::WIDTH
);

    logic [2:0]       req;
    logic [WIDTH-1:0] entradaA;
    logic [WIDTH-1:0] entradaB;
    logic [WIDTH-1:0] entradaC;
    logic [2:0]       ack;
    logic [1:0]       sel_mux;
    logic             enable;
    logic [WIDTH-1:0] saida_registrador;
    logic             ocupado;
    logic [7:0]       contador;

    modport master (
        output req,
        output entradaA,
        output entradaB,
        output entradaC,
        input  ack,
        input  sel_mux,
        input  enable,
        input  saida_registrador,
        input  ocupado,
        input  contador
    );

    modport slave (
        input  req,
        input  entradaA,
        input  entradaB,
        input  entradaC,
        output ack,
        output sel_mux,
        output enable,
        output saida_registrador,
        output ocupado,
        output contador
    );

endinterface

// File: rtl/arbitro_registrador_carga.sv
// registrador_carga: WIDTH-bit register loaded from a 3:1 mux.
// Ports: clk, rst (sync, active-high), en (load), sel (0=A,1=B,2=C),
//   in_a/in_b/in_c (data), q (register contents).
module registrador_carga
    import registrador_pkg::*;
#(
    parameter int WIDTH = registrador_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] mux;

    always_comb begin
        mux = in_a;
        case (sel)
            SEL_A:   mux = in_a;
            SEL_B:   mux = in_b;
            SEL_C:   mux = in_c;
            default: mux = in_a;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= mux;
        end
    end

endmodule

// File: rtl/arbitro_registrador.sv
// arbitro_registrador: round-robin arbiter loading a shared register.
// Ports: clk, rst (sync, active-high), bus (slave side of
//   arbitro_registrador_if: req/entradas in; ack, sel_mux, enable,
//   saida_registrador, ocupado, contador out).
module arbitro_registrador
    import registrador_pkg::*;
#(
    parameter int WIDTH = registrador_pkg::WIDTH,
    parameter int N_REQ = registrador_pkg::N_REQ
) (
    input logic                 clk,
    input logic                 rst,
    arbitro_registrador_if.slave bus
);

    estado_t          estado_q;
    estado_t          estado_d;
    // g_q is both the latched grant and the registered sel_mux;
    // it only changes on a new grant, so it holds in OCIOSO.
    logic [1:0]       g_q;
    logic [1:0]       g_d;
    logic [1:0]       ptr_q;
    logic [1:0]       ptr_d;
    logic [7:0]       cnt_q;
    logic [7:0]       cnt_d;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] ack_d;
    logic             enable_d;
    logic [WIDTH-1:0] saida;

    assign req = bus.req;

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= OCIOSO;
            g_q      <= SEL_A;
            ptr_q    <= SEL_A;
            cnt_q    <= 8'd0;
        end else begin
            estado_q <= estado_d;
            g_q      <= g_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // ack and enable depend only on state and g_q, never on req.
    always_comb begin
        estado_d = estado_q;
        g_d      = g_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        enable_d = 1'b0;
        ack_d    = '0;
        case (estado_q)
            OCIOSO: begin
                if (|req) begin
                    g_d      = escolhe(req, ptr_q);
                    estado_d = CONCEDE;
                end
            end
            CONCEDE: begin
                estado_d = CARREGA;
            end
            CARREGA: begin
                enable_d = 1'b1;
                estado_d = CONFIRMA;
            end
            CONFIRMA: begin
                ack_d[g_q] = 1'b1;
                if (!req[g_q]) begin
                    estado_d = OCIOSO;
                    ptr_d    = prox_sel(g_q);
                    cnt_d    = cnt_q + 8'd1;
                end
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    registrador_carga #(
        .WIDTH (WIDTH)
    ) u_carga (
        .clk  (clk),
        .rst  (rst),
        .en   (enable_d),
        .sel  (g_q),
        .in_a (bus.entradaA),
        .in_b (bus.entradaB),
        .in_c (bus.entradaC),
        .q    (saida)
    );

    assign bus.ack               = ack_d;
    assign bus.sel_mux           = g_q;
    assign bus.enable            = enable_d;
    assign bus.saida_registrador = saida;
    assign bus.ocupado           = (estado_q != OCIOSO);
    assign bus.contador          = cnt_q;

endmodule

// File: tb/tb_arbitro_registrador.sv
// tb_arbitro_registrador: table vectors, hand sequences and random
// transfers checked against a transaction-level round-robin model.
module tb_arbitro_registrador;

    logic clk = 1'b0;
    logic rst = 1'b1;

    arbitro_registrador_if #(.WIDTH(4)) bus ();

    arbitro_registrador #(
        .WIDTH (4),
        .N_REQ (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int m_ptr = 0;
    int m_cnt = 0;
    int last_g = 0;

    typedef struct {
        logic [2:0] req;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
        int         hold;
        int         exp_g;
        logic [3:0] exp_q;
    } vec_t;

    vec_t tbl [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Reference arbitration: first requester at or after the pointer.
    function automatic int pick(input logic [2:0] r, input int p);
        for (int k = 0; k < 3; k++) begin
            if (r[(p + k) % 3]) return (p + k) % 3;
        end
        return 0;
    endfunction

    task automatic do_reset();
        rst     = 1'b1;
        bus.req = 3'b111;
        step();
        step();
        chk("rst.ack", bus.ack, 0);
        chk("rst.enable", bus.enable, 0);
        chk("rst.saida", bus.saida_registrador, 0);
        chk("rst.contador", bus.contador, 0);
        chk("rst.ocupado", bus.ocupado, 0);
        chk("rst.sel", bus.sel_mux, 0);
        bus.req = 3'b000;
        rst     = 1'b0;
        m_ptr   = 0;
        m_cnt   = 0;
        last_g  = 0;
    endtask

    // One complete transfer: grant g, capture q, hold, then release.
    task automatic xfer(input string tag,
                        input logic [2:0] r,
                        input logic [3:0] a,
                        input logic [3:0] b,
                        input logic [3:0] c,
                        input int hold,
                        input int g,
                        input logic [3:0] q);
        logic [2:0] oh;
        oh = 3'b001 << g;
        bus.req      = r;
        bus.entradaA = a;
        bus.entradaB = b;
        bus.entradaC = c;
        step();
        chk({tag, ".concede.ocupado"}, bus.ocupado, 1);
        chk({tag, ".concede.enable"}, bus.enable, 0);
        chk({tag, ".concede.sel"}, bus.sel_mux, g);
        chk({tag, ".concede.ack"}, bus.ack, 0);
        step();
        chk({tag, ".carrega.enable"}, bus.enable, 1);
        chk({tag, ".carrega.sel"}, bus.sel_mux, g);
        step();
        chk({tag, ".confirma.ack"}, bus.ack, oh);
        chk({tag, ".confirma.saida"}, bus.saida_registrador, q);
        chk({tag, ".confirma.enable"}, bus.enable, 0);
        for (int h = 0; h < hold; h++) begin
            step();
            chk({tag, ".hold.ack"}, bus.ack, oh);
        end
        bus.req = r & ~oh;
        step();
        m_cnt  = (m_cnt + 1) % 256;
        m_ptr  = (g + 1) % 3;
        last_g = g;
        chk({tag, ".fim.ack"}, bus.ack, 0);
        chk({tag, ".fim.ocupado"}, bus.ocupado, 0);
        chk({tag, ".fim.contador"}, bus.contador, m_cnt);
    endtask

    initial begin
        logic [2:0] r;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
        int         g;
        logic [3:0] q;

        bus.req      = 3'b000;
        bus.entradaA = 4'h0;
        bus.entradaB = 4'h0;
        bus.entradaC = 4'h0;

        tbl[0] = '{3'b001, 4'h5, 4'h0, 4'h0, 0, 0, 4'h5};
        tbl[1] = '{3'b110, 4'h1, 4'h9, 4'h2, 1, 1, 4'h9};
        tbl[2] = '{3'b111, 4'h3, 4'h4, 4'hC, 0, 2, 4'hC};
        tbl[3] = '{3'b110, 4'h0, 4'h3, 4'hE, 2, 1, 4'h3};
        tbl[4] = '{3'b110, 4'h0, 4'h3, 4'h7, 0, 2, 4'h7};
        tbl[5] = '{3'b100, 4'h0, 4'h0, 4'h1, 0, 2, 4'h1};
        tbl[6] = '{3'b011, 4'hA, 4'hB, 4'h0, 0, 0, 4'hA};
        tbl[7] = '{3'b101, 4'hF, 4'h0, 4'h6, 3, 2, 4'h6};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            xfer($sformatf("tbl%0d", i), tbl[i].req, tbl[i].a,
                 tbl[i].b, tbl[i].c, tbl[i].hold,
                 tbl[i].exp_g, tbl[i].exp_q);
        end

        // All three requesting; each re-raises after its ack.
        do_reset();
        xfer("rr0", 3'b111, 4'h1, 4'h2, 4'h3, 0, 0, 4'h1);
        xfer("rr1", 3'b111, 4'h1, 4'h2, 4'h3, 0, 1, 4'h2);
        xfer("rr2", 3'b111, 4'h1, 4'h2, 4'h3, 0, 2, 4'h3);
        xfer("rr3", 3'b111, 4'h1, 4'h2, 4'h3, 0, 0, 4'h1);

        // Request withdrawn during CONCEDE: transfer still finishes.
        bus.req      = 3'b010;
        bus.entradaB = 4'hD;
        step();
        bus.req = 3'b000;
        chk("drop.sel", bus.sel_mux, 1);
        step();
        chk("drop.enable", bus.enable, 1);
        step();
        chk("drop.ack", bus.ack, 3'b010);
        chk("drop.saida", bus.saida_registrador, 4'hD);
        step();
        m_cnt = m_cnt + 1;
        chk("drop.fim.ack", bus.ack, 0);
        chk("drop.fim.ocupado", bus.ocupado, 0);
        chk("drop.fim.contador", bus.contador, m_cnt);

        // Reset while loading C: nothing captured, pointer back to A.
        do_reset();
        xfer("pre", 3'b001, 4'h6, 4'h0, 4'h8, 0, 0, 4'h6);
        bus.req      = 3'b100;
        bus.entradaC = 4'h8;
        step();
        chk("mid.sel", bus.sel_mux, 2);
        step();
        chk("mid.enable", bus.enable, 1);
        rst     = 1'b1;
        bus.req = 3'b000;
        step();
        chk("mid.saida", bus.saida_registrador, 0);
        chk("mid.ack", bus.ack, 0);
        chk("mid.contador", bus.contador, 0);
        chk("mid.ocupado", bus.ocupado, 0);
        rst   = 1'b0;
        m_ptr = 0;
        m_cnt = 0;
        xfer("pos", 3'b111, 4'h2, 4'h5, 4'h8, 0, 0, 4'h2);

        // 256 random transfers: checks arbitration order and wrap.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            int idle;
            idle = $urandom_range(0, 2);
            for (int k = 0; k < idle; k++) begin
                bus.req = 3'b000;
                step();
                chk("idle.ocupado", bus.ocupado, 0);
                chk("idle.ack", bus.ack, 0);
                chk("idle.enable", bus.enable, 0);
                chk("idle.sel", bus.sel_mux, last_g);
            end
            r = 3'($urandom_range(1, 7));
            a = 4'($urandom);
            b = 4'($urandom);
            c = 4'($urandom);
            g = pick(r, m_ptr);
            q = (g == 0) ? a : (g == 1) ? b : c;
            xfer($sformatf("rnd%0d", i), r, a, b, c,
                 (i == 0) ? 5 : $urandom_range(0, 2), g, q);
        end
        chk("wrap.contador", bus.contador, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
